intdiv_ctrl: RTL and testbench

Handshake controller that wraps the fixed-latency pipelined SD2 integer divider (`intdiv_intdiv`), which has no stall or valid signals. The controller sits directly upstream of the divider and drives its `x`/`y` operands. It also sits directly downstream: it captures `reg_z`/`reg_r` on the right cycle, handles divide-by-zero and overflow, and presents results through a valid/ready output FIFO. Credit-based admission guarantees that no in-flight result is ever lost to backpressure.

---
 rtl/intdiv_ctrl.sv | 148 ++++++++++++++
 tb/tb_intdiv_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intdiv_ctrl.sv
// Valid/ready wrapper around a fixed-latency pipelined signed divider: classifies operands,
// tracks in-flight operations with a tag pipe and buffers results in a credit-guarded FIFO.
module intdiv_ctrl #(
    parameter int unsigned N     = 4,
    parameter int unsigned LAT   = 6,
    parameter int unsigned DEPTH = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_x,
    input  logic [N-1:0] in_y,
    output logic [N-1:0] div_x,
    output logic [N-1:0] div_y,
    input  logic [N-1:0] div_z,
    input  logic [N-1:0] div_r,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_z,
    output logic [N-1:0] out_r,
    output logic         out_dz,
    output logic         out_ovf
);

    localparam int unsigned PtrW  = $clog2(DEPTH);
    localparam int unsigned CredW = $clog2(DEPTH + 1);
    localparam logic [N-1:0] MinVal = {1'b1, {(N-1){1'b0}}};

    logic dz;
    logic ovf;
    logic accept;
    logic wr_en;
    logic pop;

    // Operand classification and divider drive
    always_comb begin
        dz    = (in_y == '0);
        ovf   = (in_x == MinVal) && (in_y == '1) && !dz;
        div_x = in_x;
        div_y = (dz || ovf) ? N'(1) : in_y;
    end

    assign accept = in_valid && in_ready;

    // Tag pipe: bit i is stage i; the top stage lines up with the divider output
    logic [LAT-1:0] tag_v_q,   tag_v_d;
    logic [LAT-1:0] tag_dz_q,  tag_dz_d;
    logic [LAT-1:0] tag_ovf_q, tag_ovf_d;

    always_comb begin
        tag_v_d   = (tag_v_q   << 1) | LAT'(accept);
        tag_dz_d  = (tag_dz_q  << 1) | LAT'(dz);
        tag_ovf_d = (tag_ovf_q << 1) | LAT'(ovf);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tag_v_q   <= '0;
            tag_dz_q  <= '0;
            tag_ovf_q <= '0;
        end else begin
            tag_v_q   <= tag_v_d;
            tag_dz_q  <= tag_dz_d;
            tag_ovf_q <= tag_ovf_d;
        end
    end

    // Result formatting at the write point
    logic [N-1:0] wr_z;
    logic [N-1:0] wr_r;
    logic         wr_dz;
    logic         wr_ovf;

    always_comb begin
        wr_en  = tag_v_q[LAT-1];
        wr_dz  = tag_dz_q[LAT-1];
        wr_ovf = tag_ovf_q[LAT-1];
        wr_z   = wr_dz ? '1 : div_z;
        wr_r   = wr_dz ? div_z : div_r;
    end

    // Output FIFO storage, not reset: contents are qualified by the count
    logic [N-1:0] mem_z_q   [DEPTH];
    logic [N-1:0] mem_r_q   [DEPTH];
    logic         mem_dz_q  [DEPTH];
    logic         mem_ovf_q [DEPTH];

    logic [PtrW-1:0]  wr_ptr_q,   wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q,   rd_ptr_d;
    logic [CredW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [CredW-1:0] credits_q,  credits_d;

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_z_q[wr_ptr_q]   <= wr_z;
            mem_r_q[wr_ptr_q]   <= wr_r;
            mem_dz_q[wr_ptr_q]  <= wr_dz;
            mem_ovf_q[wr_ptr_q] <= wr_ovf;
        end
    end

    always_comb begin
        out_valid = (fifo_cnt_q != '0);
        pop       = out_valid && out_ready;
        in_ready  = (credits_q < CredW'(DEPTH));
        out_z     = out_valid ? mem_z_q[rd_ptr_q]   : '0;
        out_r     = out_valid ? mem_r_q[rd_ptr_q]   : '0;
        out_dz    = out_valid ? mem_dz_q[rd_ptr_q]  : 1'b0;
        out_ovf   = out_valid ? mem_ovf_q[rd_ptr_q] : 1'b0;
    end

    always_comb begin
        wr_ptr_d   = wr_en ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d   = pop   ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (wr_en && !pop) begin
            fifo_cnt_d = fifo_cnt_q + CredW'(1);
        end else if (!wr_en && pop) begin
            fifo_cnt_d = fifo_cnt_q - CredW'(1);
        end
        // Credits cover both in-flight and stored operations
        credits_d = credits_q;
        if (accept && !pop) begin
            credits_d = credits_q + CredW'(1);
        end else if (!accept && pop) begin
            credits_d = credits_q - CredW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            credits_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            credits_q  <= credits_d;
        end
    end

    fifo_no_overflow_a: assert property (@(posedge clock) disable iff (!reset)
        wr_en |-> (fifo_cnt_q < CredW'(DEPTH)));

endmodule

// File: tb/tb_intdiv_ctrl.sv
// Bench for intdiv_ctrl: a behavioural divider feeds the DUT; a queue-based result model is
// compared every cycle, and directed vectors pin hand-computed values.
module tb_intdiv_ctrl;

    localparam int N     = 4;
    localparam int LAT   = 6;
    localparam int DEPTH = 8;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] in_x = '0;
    logic [N-1:0] in_y = '0;
    logic [N-1:0] div_x;
    logic [N-1:0] div_y;
    logic [N-1:0] div_z;
    logic [N-1:0] div_r;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [N-1:0] out_z;
    logic [N-1:0] out_r;
    logic         out_dz;
    logic         out_ovf;

    intdiv_ctrl #(.N(N), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_x     (in_x),
        .in_y     (in_y),
        .div_x    (div_x),
        .div_y    (div_y),
        .div_z    (div_z),
        .div_r    (div_r),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_z    (out_z),
        .out_r    (out_r),
        .out_dz   (out_dz),
        .out_ovf  (out_ovf)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;

    function automatic void chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endfunction

    // Divider: LAT registers, the first one sampling the operands
    function automatic logic [2*N-1:0] sdiv(input logic [N-1:0] x, input logic [N-1:0] y);
        int xs;
        int ys;
        xs = int'($signed(x));
        ys = int'($signed(y));
        if (ys == 0) return '0;
        return {N'(xs / ys), N'(xs % ys)};
    endfunction

    logic [2*N-1:0] dpipe [LAT];
    always @(posedge clock) begin
        dpipe[0] <= sdiv(div_x, div_y);
        for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
    end
    assign div_z = dpipe[LAT-1][2*N-1:N];
    assign div_r = dpipe[LAT-1][N-1:0];

    // Result model: one entry per accepted op, visible from edge index rdy onward
    typedef struct {
        logic [N-1:0] z;
        logic [N-1:0] r;
        logic         dz;
        logic         ovf;
        int           rdy;
    } res_t;

    res_t mq[$];
    res_t lit_q[$];
    int   cyc = 0;

    function automatic res_t golden(input logic [N-1:0] x, input logic [N-1:0] y, input int rdy);
        res_t e;
        int xs;
        int ys;
        xs    = int'($signed(x));
        ys    = int'($signed(y));
        e.dz  = 1'b0;
        e.ovf = 1'b0;
        e.rdy = rdy;
        if (ys == 0) begin
            e.z  = '1;
            e.r  = x;
            e.dz = 1'b1;
        end else if (xs == -(1 << (N - 1)) && ys == -1) begin
            e.z   = x;
            e.r   = '0;
            e.ovf = 1'b1;
        end else begin
            e.z = N'(xs / ys);
            e.r = N'(xs % ys);
        end
        return e;
    endfunction

    function automatic bit model_valid();
        return reset && (mq.size() > 0) && (mq[0].rdy <= cyc);
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mq.delete();
        end else begin
            if (in_valid && mq.size() < DEPTH) mq.push_back(golden(in_x, in_y, cyc + 1 + LAT));
            if (mq.size() > 0 && mq[0].rdy <= cyc && out_ready) void'(mq.pop_front());
            cyc <= cyc + 1;
        end
    end

    // Per-cycle comparison against the model, plus literal expectations at each pop
    always @(negedge clock) begin
        chk("in_ready", int'(in_ready), int'(mq.size() < DEPTH));
        chk("out_valid", int'(out_valid), int'(model_valid()));
        if (model_valid()) begin
            chk("out_z", int'(out_z), int'(mq[0].z));
            chk("out_r", int'(out_r), int'(mq[0].r));
            chk("out_dz", int'(out_dz), int'(mq[0].dz));
            chk("out_ovf", int'(out_ovf), int'(mq[0].ovf));
            if (out_ready && lit_q.size() > 0) begin
                chk("lit_z", int'(out_z), int'(lit_q[0].z));
                chk("lit_r", int'(out_r), int'(lit_q[0].r));
                chk("lit_dz", int'(out_dz), int'(lit_q[0].dz));
                chk("lit_ovf", int'(out_ovf), int'(lit_q[0].ovf));
                void'(lit_q.pop_front());
            end
        end else begin
            chk("idle_outs", int'({out_z, out_r, out_dz, out_ovf}), 0);
        end
    end

    function automatic void lit(input int z, input int r, input bit dz, input bit ovf);
        res_t t;
        t.z   = N'(z);
        t.r   = N'(r);
        t.dz  = dz;
        t.ovf = ovf;
        t.rdy = 0;
        lit_q.push_back(t);
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input int x, input int y);
        step();
        in_valid = v;
        in_x     = N'(x);
        in_y     = N'(y);
    endtask

    int bx[8] = '{7, -7, 7, -7, 3, -8, 6, -1};
    int by[8] = '{2, 2, -2, -2, 5, 3, 6, 7};
    int bz[8] = '{3, -3, -3, 3, 0, -2, 1, 0};
    int br[8] = '{1, -1, 1, -1, 3, -2, 0, -1};

    initial begin
        int idx;
        int acc_cnt;

        repeat (3) @(posedge clock);
        #1;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_ready", int'(in_ready), 1);
        chk("rst_z", int'(out_z), 0);
        #1 reset = 1'b1;

        // Basic divisions, back to back
        lit(2, 1, 0, 0);
        lit(1, 2, 0, 0);
        lit(-1, -2, 0, 0);
        drive(1, 7, 3);
        drive(1, 6, 4);
        drive(1, -6, 4);
        drive(0, 0, 0);
        repeat (LAT - 3) @(posedge clock);
        @(negedge clock);
        chk("lat_lo", int'(out_valid), 0);
        @(negedge clock);
        chk("lat_hi", int'(out_valid), 1);
        repeat (4) step();

        // Overflow
        lit(-8, 0, 0, 1);
        drive(1, -8, -1);
        chk("ovf_div_y", int'(div_y), 1);
        chk("ovf_div_x", int'(div_x), 8);
        drive(0, 0, 0);
        repeat (LAT + 3) step();

        // Divide by zero
        lit(-1, 5, 1, 0);
        lit(-1, -3, 1, 0);
        drive(1, 5, 0);
        chk("dz_div_y", int'(div_y), 1);
        drive(1, -3, 0);
        chk("dz_div_y2", int'(div_y), 1);
        drive(0, 0, 0);
        repeat (LAT + 3) step();

        // Backpressure: offer continuously with the consumer stalled
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) lit(bz[i], br[i], 0, 0);
        idx     = 0;
        acc_cnt = 0;
        for (int c = 0; c < 14; c++) begin
            step();
            in_valid = 1'b1;
            in_x     = (idx < 8) ? N'(bx[idx]) : N'(1);
            in_y     = (idx < 8) ? N'(by[idx]) : N'(1);
            @(negedge clock);
            if (in_ready) begin
                idx++;
                acc_cnt++;
            end
        end
        chk("bp_accepts", acc_cnt, 8);
        step();
        in_valid = 1'b0;
        @(negedge clock);
        chk("bp_full", int'(in_ready), 0);
        chk("bp_head_valid", int'(out_valid), 1);
        chk("bp_head_z", int'(out_z), 3);
        step();
        out_ready = 1'b1;
        @(negedge clock);
        chk("bp_pre_pop", int'(in_ready), 0);
        @(negedge clock);
        chk("bp_post_pop", int'(in_ready), 1);
        repeat (10) step();

        // Seven stored, then accept and pop on the same edge
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) drive(1, i, 1);
        drive(0, 0, 0);
        repeat (LAT + 2) step();
        @(negedge clock);
        chk("cr7_ready", int'(in_ready), 1);
        step();
        in_valid  = 1'b1;
        in_x      = N'(5);
        in_y      = N'(2);
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clock);
        chk("cr7_hold", int'(in_ready), 1);
        drive(1, 3, 3);
        drive(0, 0, 0);
        @(negedge clock);
        chk("cr8_full", int'(in_ready), 0);
        step();
        out_ready = 1'b1;
        repeat (LAT + 12) step();

        // Reset with three ops in flight and two stored
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) drive(1, i + 1, 2);
        drive(0, 0, 0);
        repeat (3) @(posedge clock);
        #2;
        chk("pre_rst_valid", int'(out_valid), 1);
        reset = 1'b0;
        #1;
        chk("rst_async_valid", int'(out_valid), 0);
        chk("rst_async_ready", int'(in_ready), 1);
        @(posedge clock);
        #2 reset = 1'b1;
        for (int i = 0; i < LAT + 2; i++) begin
            @(negedge clock);
            chk("rst_stale", int'(out_valid), 0);
        end
        step();
        out_ready = 1'b1;
        lit(3, 1, 0, 0);
        drive(1, 7, 2);
        drive(0, 0, 0);
        repeat (LAT + 4) step();

        @(negedge clock);
        chk("lit_drained", lit_q.size(), 0);
        chk("end_idle", int'(out_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench timeout");
    end

endmodule
